// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its CPU, GPU and VRAM neighbours.
// The slave modport is the arbiter's view; master is the surrounding system.
interface vram_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
);
    // CPU word port
    logic                  CPU_ENABLE;
    logic                  CPU_WRITE;
    logic [ADDR_WIDTH-1:0] CPU_ADDR;
    logic [DATA_WIDTH-1:0] CPU_DATA_W;
    logic [DATA_WIDTH-1:0] CPU_DATA_R;
    logic                  CPU_ACK;
    logic                  CPU_COMMIT;
    logic                  CPU_BUSY;

    // GPU master port and draw handshake
    logic                  GPU_ENABLE;
    logic                  GPU_WRITE;
    logic [ADDR_WIDTH-1:0] GPU_ADDR;
    logic [DATA_WIDTH-1:0] GPU_DATA_W;
    logic [DATA_WIDTH-1:0] GPU_DATA_R;
    logic                  GPU_LOCK;
    logic                  GPU_READY;
    logic                  GPU_DRAW;
    logic [15:0]           FRAME_CNT;

    // Single-port VRAM
    logic                  RAM_ENABLE;
    logic                  RAM_WRITE;
    logic [ADDR_WIDTH-1:0] RAM_ADDR;
    logic [DATA_WIDTH-1:0] RAM_DATA_W;
    logic [DATA_WIDTH-1:0] RAM_DATA_R;

    modport slave (
        input  CPU_ENABLE, CPU_WRITE, CPU_ADDR, CPU_DATA_W, CPU_COMMIT,
        output CPU_DATA_R, CPU_ACK, CPU_BUSY,
        input  GPU_ENABLE, GPU_WRITE, GPU_ADDR, GPU_DATA_W, GPU_LOCK, GPU_READY,
        output GPU_DATA_R, GPU_DRAW, FRAME_CNT,
        output RAM_ENABLE, RAM_WRITE, RAM_ADDR, RAM_DATA_W,
        input  RAM_DATA_R
    );

    modport master (
        output CPU_ENABLE, CPU_WRITE, CPU_ADDR, CPU_DATA_W, CPU_COMMIT,
        input  CPU_DATA_R, CPU_ACK, CPU_BUSY,
        output GPU_ENABLE, GPU_WRITE, GPU_ADDR, GPU_DATA_W, GPU_LOCK, GPU_READY,
        input  GPU_DATA_R, GPU_DRAW, FRAME_CNT,
        input  RAM_ENABLE, RAM_WRITE, RAM_ADDR, RAM_DATA_W,
        output RAM_DATA_R
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between CPU word accesses and the GPU, honours
// the GPU lock, and turns CPU frame commits into one-cycle GPU draw pulses.
module vram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic           CLK,
    input  logic           RESET,
    vram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACCESS    = 2'd1,
        READ_DATA = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic                  cmd_write_q, cmd_write_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  draw_q, draw_d;
    logic                  pending_q, pending_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  draw_fire;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_write_q <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            draw_q      <= 1'b0;
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_write_q <= cmd_write_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            draw_q      <= draw_d;
            pending_q   <= pending_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // CPU access sequencer; the ACK cycle itself never starts a new access.
    always_comb begin
        state_d     = state_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_write_d = cmd_write_q;
        ack_d       = 1'b0;
        rdata_d     = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (bus.CPU_ENABLE && !bus.GPU_LOCK && !ack_q) begin
                    cmd_addr_d  = bus.CPU_ADDR;
                    cmd_data_d  = bus.CPU_DATA_W;
                    cmd_write_d = bus.CPU_WRITE;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cmd_write_q) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = READ_DATA;
                end
            end
            READ_DATA: begin
                rdata_d = bus.RAM_DATA_R;
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A commit landing in the same cycle as a draw re-arms pending for the next frame.
    always_comb begin
        draw_fire   = pending_q & bus.GPU_READY & ~bus.GPU_LOCK & ~draw_q;
        draw_d      = draw_fire;
        pending_d   = bus.CPU_COMMIT | (pending_q & ~draw_fire);
        frame_cnt_d = draw_fire ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    always_comb begin
        if (state_q == ACCESS) begin
            bus.RAM_ENABLE = 1'b1;
            bus.RAM_WRITE  = cmd_write_q;
            bus.RAM_ADDR   = cmd_addr_q;
            bus.RAM_DATA_W = cmd_data_q;
        end else begin
            bus.RAM_ENABLE = bus.GPU_ENABLE & bus.GPU_LOCK;
            bus.RAM_WRITE  = bus.GPU_WRITE;
            bus.RAM_ADDR   = bus.GPU_ADDR;
            bus.RAM_DATA_W = bus.GPU_DATA_W;
        end
    end

    assign bus.CPU_DATA_R = rdata_q;
    assign bus.CPU_ACK    = ack_q;
    assign bus.CPU_BUSY   = bus.GPU_LOCK | pending_q;
    assign bus.GPU_DATA_R = bus.RAM_DATA_R;
    assign bus.GPU_DRAW   = draw_q;
    assign bus.FRAME_CNT  = frame_cnt_q;

endmodule
